// File: rtl/scdm_accum_pkg.sv
// Shared definitions for the SCDM dot-product accumulator.
//   - default widths for product, accumulator and term-count
//   - FSM state encoding shared by the accumulator and anything observing it
package scdm_accum_pkg;

  localparam int PROD_W_DEF = 12;
  localparam int ACC_W_DEF  = 20;
  localparam int LEN_W_DEF  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/scdm_accum_sat_add.sv
// scdm_sat_add: combinational sign-extended saturating adder.
// Ports:
//   a   in  A_W  signed accumulator operand
//   b   in  B_W  signed addend (B_W < A_W)
//   sum out A_W  a+b clamped to the signed A_W range
//   ovf out 1    clamp applied
module scdm_sat_add #(
  parameter int A_W = 20,
  parameter int B_W = 12
) (
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [A_W-1:0] sum,
  output logic           ovf
);

  logic [A_W:0] a_x;
  logic [A_W:0] b_x;
  logic [A_W:0] wide;

  assign a_x  = {a[A_W-1], a};
  assign b_x  = {{(A_W + 1 - B_W){b[B_W-1]}}, b};
  assign wide = a_x + b_x;

  // With one extra bit the true sum always fits; the two top bits disagree
  // exactly when it leaves the A_W range, and the top bit gives the direction.
  always_comb begin
    ovf = wide[A_W] ^ wide[A_W-1];
    if (!ovf) begin
      sum = wide[A_W-1:0];
    end else if (wide[A_W]) begin
      sum = {1'b1, {(A_W-1){1'b0}}};
    end else begin
      sum = {1'b0, {(A_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/scdm_accum.sv
// scdm_accum: accumulates cfg_len signed products from the SCDM multiplier
// array into a saturating dot product, then holds the result until consumed.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, cfg_len       begin a dot product of cfg_len terms (0 means 1)
//   prod_valid/ready/data product input handshake
//   out_valid/ready/data result output handshake (registered)
//   out_sat              saturation occurred during this dot product
//   busy                 accumulating or holding a result
//
// state   | meaning
// S_IDLE  | waiting for start
// S_ACCUM | accepting products until len terms summed
// S_HOLD  | result presented until out_ready
module scdm_accum
  import scdm_accum_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_sat,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               sat_q, sat_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_data_q, out_data_d;
  logic               out_sat_q, out_sat_d;

  logic [ACC_W-1:0]   sum;
  logic               ovf;
  logic               load;

  scdm_sat_add #(
    .A_W (ACC_W),
    .B_W (PROD_W)
  ) u_sat_add (
    .a   (acc_q),
    .b   (prod_data),
    .sum (sum),
    .ovf (ovf)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    len_d       = len_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    load        = 1'b0;

    // prod_ready depends on state only so the upstream may gate valid on it.
    prod_ready  = (state_q == S_ACCUM);
    busy        = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        load = start;
      end
      S_ACCUM: begin
        if (prod_valid) begin
          acc_d   = sum;
          sat_d   = sat_q | ovf;
          count_d = count_q + LEN_W'(1);
          if (count_q == len_q - LEN_W'(1)) begin
            state_d     = S_HOLD;
            count_d     = '0;
            out_valid_d = 1'b1;
            out_data_d  = sum;
            out_sat_d   = sat_q | ovf;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
          load        = start;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Shared by IDLE start and the back-to-back restart out of HOLD.
    if (load) begin
      state_d   = S_ACCUM;
      len_d     = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
      acc_d     = '0;
      count_d   = '0;
      sat_d     = 1'b0;
      out_sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      len_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      len_q       <= len_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_scdm_accum.sv
// Directed bench for scdm_accum. The accumulator is built 16 bits wide here:
// at 20 bits even 255 full-scale 12-bit terms cannot reach the clamp, so the
// narrower width is what lets the saturation paths be exercised.
module tb_scdm_accum;

  localparam int PW   = 12;
  localparam int AW   = 16;
  localparam int LW   = 8;
  localparam int MAXV = (1 << (AW - 1)) - 1;
  localparam int MINV = -(1 << (AW - 1));

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic          prod_valid = 1'b0;
  logic          prod_ready;
  logic [PW-1:0] prod_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_data;
  logic          out_sat;
  logic          busy;

  scdm_accum #(.PROD_W(PW), .ACC_W(AW), .LEN_W(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_len    (cfg_len),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod_data  (prod_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer running sum, clamped after every term.
  function automatic void model_dot(input int p[$], output int res, output bit sat);
    longint a = 0;
    sat = 1'b0;
    foreach (p[i]) begin
      a += p[i];
      if (a > MAXV) begin
        a = MAXV; sat = 1'b1;
      end else if (a < MINV) begin
        a = MINV; sat = 1'b1;
      end
    end
    res = int'(a);
  endfunction

  typedef struct {
    int data;
    bit sat;
  } exp_t;

  exp_t exp_q[$];
  logic rst_s = 1'b0;

  always @(posedge clk) rst_s <= rst;

  // Every cycle: reset values after a reset edge, otherwise any presented
  // result must match the oldest pending expectation, and nothing may be
  // presented when nothing is pending.
  always @(negedge clk) begin
    if (rst_s) begin
      exp_q.delete();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", int'($signed(out_data)), 0);
      chk("rst_out_sat", out_sat, 0);
      chk("rst_prod_ready", prod_ready, 0);
      chk("rst_busy", busy, 0);
    end else if (exp_q.size() == 0) begin
      chk("no_spurious_valid", out_valid, 0);
    end else if (out_valid) begin
      chk("out_data", int'($signed(out_data)), exp_q[0].data);
      chk("out_sat", out_sat, exp_q[0].sat);
      if (out_ready) void'(exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int p[$]);
    exp_t e;
    model_dot(p, e.data, e.sat);
    exp_q.push_back(e);
  endtask

  task automatic start_dot(input int cfg, input int p[$]);
    push_exp(p);
    chk("idle_before_start", busy, 0);
    start   = 1'b1;
    cfg_len = LW'(cfg);
    tick();
    start   = 1'b0;
  endtask

  task automatic restart_dot(input int cfg, input int p[$]);
    push_exp(p);
    out_ready = 1'b1;
    start     = 1'b1;
    cfg_len   = LW'(cfg);
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic send_prod(input int v, input int gap);
    int t = 0;
    repeat (gap) tick();
    prod_valid = 1'b1;
    prod_data  = PW'(v);
    while (!prod_ready && t < 50) begin
      tick();
      t++;
    end
    if (!prod_ready) chk("prod_ready_timeout", prod_ready, 1);
    tick();
    prod_valid = 1'b0;
  endtask

  task automatic feed(input int p[$]);
    foreach (p[i]) send_prod(p[i], 0);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p[$];

    repeat (3) tick();
    chk("init_out_valid", out_valid, 0);
    chk("init_busy", busy, 0);
    rst = 1'b0;
    tick();

    // 1: three back-to-back products
    p.delete(); p.push_back(100); p.push_back(-50); p.push_back(7);
    start_dot(3, p);
    feed(p);
    chk("t1_valid_latency", out_valid, 1);
    chk("t1_out_data", int'($signed(out_data)), 57);
    chk("t1_out_sat", out_sat, 0);
    consume();
    chk("t1_valid_cleared", out_valid, 0);
    chk("t1_idle", busy, 0);

    // 2: gaps on prod_valid, result held while out_ready low
    p.delete(); p.push_back(10); p.push_back(20); p.push_back(-5); p.push_back(300);
    start_dot(4, p);
    send_prod(10, 1);
    send_prod(20, 2);
    send_prod(-5, 0);
    send_prod(300, 3);
    chk("t2_out_data", int'($signed(out_data)), 325);
    repeat (5) tick();
    chk("t2_valid_held", out_valid, 1);
    chk("t2_data_held", int'($signed(out_data)), 325);
    consume();
    chk("t2_idle", busy, 0);

    // 3: positive clamp, negative clamp with recovery, then sat clears
    p.delete();
    for (int i = 0; i < 200; i++) p.push_back(2047);
    start_dot(200, p);
    feed(p);
    chk("t3_pos_clamp", int'($signed(out_data)), 32767);
    chk("t3_pos_sat", out_sat, 1);
    consume();

    p.delete();
    for (int i = 0; i < 17; i++) p.push_back(-2048);
    p.push_back(100);
    start_dot(18, p);
    feed(p);
    chk("t3_neg_clamp_then_add", int'($signed(out_data)), -32668);
    chk("t3_neg_sat", out_sat, 1);
    consume();

    p.delete(); p.push_back(-1);
    start_dot(1, p);
    feed(p);
    chk("t3_minus_one", int'($signed(out_data)), -1);
    chk("t3_sat_cleared", out_sat, 0);
    consume();

    // 4: cfg_len 0 behaves as one term
    p.delete(); p.push_back(-2048);
    start_dot(0, p);
    feed(p);
    chk("t4_len0_data", int'($signed(out_data)), -2048);
    chk("t4_len0_valid", out_valid, 1);
    consume();

    // 5: back-to-back restart straight out of HOLD
    p.delete(); p.push_back(3);
    start_dot(1, p);
    feed(p);
    p.delete(); p.push_back(4); p.push_back(5);
    restart_dot(2, p);
    chk("t5_prod_ready", prod_ready, 1);
    chk("t5_busy", busy, 1);
    chk("t5_valid_dropped", out_valid, 0);
    feed(p);
    chk("t5_out_data", int'($signed(out_data)), 9);
    consume();

    // 6: reset mid dot product discards it
    p.delete();
    for (int i = 1; i <= 5; i++) p.push_back(i);
    start_dot(5, p);
    send_prod(1, 0);
    send_prod(2, 0);
    rst = 1'b1;
    tick();
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_prod_ready", prod_ready, 0);
    rst = 1'b0;
    repeat (6) tick();
    chk("t6_no_valid", out_valid, 0);

    p.delete(); p.push_back(7);
    start_dot(1, p);
    feed(p);
    chk("t6_after_reset", int'($signed(out_data)), 7);
    consume();

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
